// File: rtl/fft8_stage_sequencer_if.sv
// -----------------------------------------------------------------------------
// fft8_stage_sequencer_if
//
// Bundles every signal between the 8-point FFT frame sequencer and the things
// around it: the core-side input stream, the three butterfly stages and the
// output stream.
//
//   master : the sequencer (drives in_ready, stage_start, stage_din, outputs)
//   slave  : the environment (drives samples, stage results, out_ready)
//
// Signals
//   in_valid/in_ready, in_real/in_imag   input sample stream, natural order
//   stage_start[2:0]                     one-hot start strobe, bit s = stage s+1
//   stage_ready[2:0]                     one-hot result strobes from the stages
//   stage_din/stage_dout                 16 words, sample k real at word 2k,
//                                        imag at word 2k+1
//   out_valid/out_ready, out_real/out_imag, out_index   output bin stream
//   busy, err                            status
//   ifft_mode                            only present with FFT_SEQ_IFFT_EN
// -----------------------------------------------------------------------------
interface fft8_stage_sequencer_if #(
   parameter int WIDTH = 32
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [WIDTH-1:0]  in_real;
   logic signed [WIDTH-1:0]  in_imag;
   logic [2:0]               stage_start;
   logic [2:0]               stage_ready;
   logic [16*WIDTH-1:0]      stage_din;
   logic [16*WIDTH-1:0]      stage_dout;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [WIDTH-1:0]  out_real;
   logic signed [WIDTH-1:0]  out_imag;
   logic [2:0]               out_index;
   logic                     busy;
   logic                     err;
`ifdef FFT_SEQ_IFFT_EN
   logic                     ifft_mode;

   modport master (
      input  in_valid, in_real, in_imag, stage_ready, stage_dout, out_ready, ifft_mode,
      output in_ready, stage_start, stage_din, out_valid, out_real, out_imag,
             out_index, busy, err
   );
   modport slave (
      output in_valid, in_real, in_imag, stage_ready, stage_dout, out_ready, ifft_mode,
      input  in_ready, stage_start, stage_din, out_valid, out_real, out_imag,
             out_index, busy, err
   );
`else
   modport master (
      input  in_valid, in_real, in_imag, stage_ready, stage_dout, out_ready,
      output in_ready, stage_start, stage_din, out_valid, out_real, out_imag,
             out_index, busy, err
   );
   modport slave (
      output in_valid, in_real, in_imag, stage_ready, stage_dout, out_ready,
      input  in_ready, stage_start, stage_din, out_valid, out_real, out_imag,
             out_index, busy, err
   );
`endif
endinterface

// File: rtl/fft8_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fft8_stage_sequencer
//
// Frame controller for the 8-point radix-2 FFT datapath. Loads eight complex
// samples into a bit-reversed frame buffer, runs the three butterfly stages
// one after another (start strobe, wait for ready, capture the stage result
// back into the buffer), then streams the eight bins out in natural order.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; aborts any frame in progress
//   bus   fft8_stage_sequencer_if.master (streams, stage bus, status)
//
// Parameters
//   WIDTH          bits per real/imag component (two's complement)
//   STAGE_TIMEOUT  WAIT cycles allowed per stage before the sticky error
//
// Build option
//   FFT_SEQ_IFFT_EN  adds bus.ifft_mode. The mode is sampled with sample 0
//                    and held for the frame; in inverse mode the loaded imag
//                    is negated and the output is (re, -im) >>> 3.
// -----------------------------------------------------------------------------
module fft8_stage_sequencer #(
   parameter int WIDTH         = 32,
   parameter int STAGE_TIMEOUT = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   fft8_stage_sequencer_if.master bus
);

   localparam logic [2:0] ST_LOAD   = 3'd0;
   localparam logic [2:0] ST_ISSUE  = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_UNLOAD = 3'd3;
   localparam logic [2:0] ST_ERR    = 3'd4;

   // Counter only has to hold 0..STAGE_TIMEOUT-1: the last WAIT cycle is the
   // one where it equals STAGE_TIMEOUT-1.
   localparam int            TW       = (STAGE_TIMEOUT < 2) ? 1 : $clog2(STAGE_TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(STAGE_TIMEOUT - 1);

   logic [2:0]              state_reg;
   logic [2:0]              state_next;
   logic [2:0]              load_cnt_reg;
   logic [1:0]              stage_reg;
   logic [TW-1:0]           tmo_reg;
   logic [2:0]              out_index_reg;
   logic signed [WIDTH-1:0] buf_re_reg [8];
   logic signed [WIDTH-1:0] buf_im_reg [8];

   logic                    load_fire;
   logic                    capture;
   logic                    tmo_hit;
   logic                    out_fire;
   logic [2:0]              load_addr;
   logic signed [WIDTH-1:0] load_im;
   logic signed [WIDTH-1:0] sel_re;
   logic signed [WIDTH-1:0] sel_im;

   function automatic logic [2:0] bitrev3(input logic [2:0] n);
      return {n[0], n[1], n[2]};
   endfunction

   // in_ready is gated by rst so it already reads 0 during the reset cycle,
   // whatever state the frame was in.
   assign bus.in_ready = (state_reg == ST_LOAD) && !rst;
   assign load_fire    = bus.in_valid && bus.in_ready;
   assign capture      = (state_reg == ST_WAIT) && bus.stage_ready[stage_reg];
   assign tmo_hit      = (tmo_reg == TMO_LAST);
   assign out_fire     = (state_reg == ST_UNLOAD) && bus.out_ready;
   assign load_addr    = bitrev3(load_cnt_reg);

   assign sel_re = buf_re_reg[out_index_reg];
   assign sel_im = buf_im_reg[out_index_reg];

`ifdef FFT_SEQ_IFFT_EN
   logic                    mode_reg;
   logic                    load_mode;
   logic signed [WIDTH-1:0] neg_im;

   // Sample 0 must already see the mode being latched alongside it.
   assign load_mode    = (load_cnt_reg == 3'd0) ? bus.ifft_mode : mode_reg;
   assign load_im      = load_mode ? -bus.in_imag : bus.in_imag;
   assign neg_im       = -sel_im;
   assign bus.out_real = mode_reg ? (sel_re >>> 3) : sel_re;
   assign bus.out_imag = mode_reg ? (neg_im >>> 3) : sel_im;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_reg <= 1'b0;
      end else if (load_fire && (load_cnt_reg == 3'd0)) begin
         mode_reg <= bus.ifft_mode;
      end
   end
`else
   assign load_im      = bus.in_imag;
   assign bus.out_real = sel_re;
   assign bus.out_imag = sel_im;
`endif

   // Next-state logic. A ready in the last allowed WAIT cycle beats the timeout.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_LOAD:   if (load_fire && (load_cnt_reg == 3'd7)) state_next = ST_ISSUE;
         ST_ISSUE:  state_next = ST_WAIT;
         ST_WAIT: begin
            if (capture) begin
               state_next = (stage_reg == 2'd2) ? ST_UNLOAD : ST_ISSUE;
            end else if (tmo_hit) begin
               state_next = ST_ERR;
            end
         end
         ST_UNLOAD: if (out_fire && (out_index_reg == 3'd7)) state_next = ST_LOAD;
         ST_ERR:    state_next = ST_ERR;
         default:   state_next = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_LOAD;
         load_cnt_reg  <= 3'd0;
         stage_reg     <= 2'd0;
         tmo_reg       <= '0;
         out_index_reg <= 3'd0;
      end else begin
         state_reg <= state_next;
         if (load_fire) begin
            load_cnt_reg <= load_cnt_reg + 3'd1;
         end
         if (state_reg == ST_ISSUE) begin
            tmo_reg <= '0;
         end else if ((state_reg == ST_WAIT) && !capture) begin
            tmo_reg <= tmo_reg + 1'b1;
         end
         // Stage index returns to 0 after the last stage, ready for the next frame.
         if (capture) begin
            stage_reg <= (stage_reg == 2'd2) ? 2'd0 : stage_reg + 2'd1;
         end
         if (out_fire) begin
            out_index_reg <= out_index_reg + 3'd1;
         end
      end
   end

   // Frame buffer: written one entry at a time while loading, all at once on
   // a stage capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            buf_re_reg[i] <= '0;
            buf_im_reg[i] <= '0;
         end
      end else if (capture) begin
         for (int i = 0; i < 8; i++) begin
            buf_re_reg[i] <= bus.stage_dout[(2*i)*WIDTH +: WIDTH];
            buf_im_reg[i] <= bus.stage_dout[(2*i+1)*WIDTH +: WIDTH];
         end
      end else if (load_fire) begin
         buf_re_reg[load_addr] <= bus.in_real;
         buf_im_reg[load_addr] <= load_im;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_din
         assign bus.stage_din[(2*gi)*WIDTH +: WIDTH]   = buf_re_reg[gi];
         assign bus.stage_din[(2*gi+1)*WIDTH +: WIDTH] = buf_im_reg[gi];
      end
   endgenerate

   assign bus.stage_start = (state_reg == ST_ISSUE) ? (3'b001 << stage_reg) : 3'b000;
   assign bus.out_valid   = (state_reg == ST_UNLOAD);
   assign bus.out_index   = out_index_reg;
   assign bus.busy        = (state_reg != ST_LOAD);
   assign bus.err         = (state_reg == ST_ERR);

endmodule

// File: tb/tb_fft8_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft8_stage_sequencer
//
// Directed bench for the 8-point FFT frame sequencer. A behavioural stage
// model answers stage_start after a programmable latency, either with a real
// radix-2 DIT butterfly pass or with a "marker" pass that adds 2^s to every
// real word so each capture is visible in the output.
// -----------------------------------------------------------------------------
module tb_fft8_stage_sequencer;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fft8_stage_sequencer_if #(.WIDTH(W)) bus ();

   fft8_stage_sequencer #(.WIDTH(W), .STAGE_TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // stage model controls
   int         model_lat  = 1;
   int         model_kind = 0;   // 0 = DIT butterfly, 1 = marker
   logic [2:0] mute       = 3'b000;
   logic [2:0] pend;
   int         cd;

   real cos_t [4] = '{1.0, 0.70710678118654752, 0.0, -0.70710678118654752};
   real sin_t [4] = '{0.0, 0.70710678118654752, 1.0,  0.70710678118654752};

   int ld_re [8];
   int ld_im [8];
   int exp_re [8];
   int exp_im [8];
   int got_re [8];
   int got_im [8];
   int got_idx [8];
   int n_out, last_t, first_ov_t, err_t;

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
   endfunction

   function automatic logic [16*W-1:0] stage_calc(input logic [16*W-1:0] din,
                                                  input logic [2:0] onehot,
                                                  input int kind);
      logic [16*W-1:0] r;
      int s, h, tw;
      real ar, ai, br, bi, wr, wi;
      s = onehot[0] ? 0 : (onehot[1] ? 1 : 2);
      r = din;
      if (kind == 1) begin
         for (int k = 0; k < 8; k++)
            r[(2*k)*W +: W] = $signed(din[(2*k)*W +: W]) + (1 << s);
      end else begin
         h = 1 << s;
         for (int g = 0; g < 8; g += 2*h) begin
            for (int j = 0; j < h; j++) begin
               tw = j * (4 >> s);
               ar = real'($signed(din[(2*(g+j))*W +: W]));
               ai = real'($signed(din[(2*(g+j)+1)*W +: W]));
               br = real'($signed(din[(2*(g+j+h))*W +: W]));
               bi = real'($signed(din[(2*(g+j+h)+1)*W +: W]));
               wr = br * cos_t[tw] + bi * sin_t[tw];
               wi = bi * cos_t[tw] - br * sin_t[tw];
               r[(2*(g+j))*W +: W]     = rnd(ar + wr);
               r[(2*(g+j)+1)*W +: W]   = rnd(ai + wi);
               r[(2*(g+j+h))*W +: W]   = rnd(ar - wr);
               r[(2*(g+j+h)+1)*W +: W] = rnd(ai - wi);
            end
         end
      end
      return r;
   endfunction

   always @(posedge clk) begin
      bus.stage_ready <= 3'b000;
      if (rst) begin
         cd <= 0;
      end else if (|bus.stage_start) begin
         if (model_lat <= 1) begin
            bus.stage_ready <= bus.stage_start & ~mute;
            bus.stage_dout  <= stage_calc(bus.stage_din, bus.stage_start, model_kind);
         end else begin
            cd   <= model_lat - 1;
            pend <= bus.stage_start;
         end
      end else if (cd > 0) begin
         cd <= cd - 1;
         if (cd == 1) begin
            bus.stage_ready <= pend & ~mute;
            bus.stage_dout  <= stage_calc(bus.stage_din, pend, model_kind);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("rst_in_ready_low", bus.in_ready, 0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_err", bus.err, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_stage_start", bus.stage_start, 0);
      check("rst_out_index", bus.out_index, 0);
      check("rst_out_real", bus.out_real, 0);
      check("rst_out_imag", bus.out_imag, 0);
   endtask

   // Drives ld_re/ld_im and collects up to 8 outputs; t counts cycles from
   // the first load cycle.
   task automatic run_frame(input int rdy_mode, input int max_cycles, input bit check_din);
      int li;
      logic held;
      int h_idx, h_re, h_im;
      int bitrev_tbl [8];
      bitrev_tbl = '{0, 4, 2, 6, 1, 5, 3, 7};
      li = 0; n_out = 0; last_t = 0; first_ov_t = 0; err_t = 0; held = 1'b0;
      h_idx = 0; h_re = 0; h_im = 0;
      for (int t = 1; t <= max_cycles && n_out < 8; t++) begin
         if (li < 8) begin
            bus.in_valid = 1'b1;
            bus.in_real  = ld_re[li];
            bus.in_imag  = ld_im[li];
         end else begin
            bus.in_valid = 1'b0;
         end
         bus.out_ready = (rdy_mode == 0) ? 1'b1 : t[0];
         #1;
         if (check_din && t == 9) begin
            check("issue_stage_start", bus.stage_start, 3'b001);
            for (int k = 0; k < 8; k++)
               check($sformatf("din_entry%0d", k), $signed(bus.stage_din[(2*k)*W +: W]), bitrev_tbl[k]);
         end
         if (bus.err && err_t == 0) err_t = t;
         if (bus.out_valid && first_ov_t == 0) first_ov_t = t;
         if (held) begin
            check("hold_index", bus.out_index, h_idx);
            check("hold_real", bus.out_real, h_re);
            check("hold_imag", bus.out_imag, h_im);
         end
         held = bus.out_valid && !bus.out_ready;
         if (held) begin
            h_idx = int'(bus.out_index); h_re = bus.out_real; h_im = bus.out_imag;
         end
         if (bus.in_valid && bus.in_ready) begin
            $display("t=%0d load n=%0d re=%0d im=%0d", t, li, ld_re[li], ld_im[li]);
            li++;
         end
         if (bus.out_valid && bus.out_ready) begin
            got_idx[n_out] = int'(bus.out_index);
            got_re[n_out]  = bus.out_real;
            got_im[n_out]  = bus.out_imag;
            $display("t=%0d out bin=%0d re=%0d im=%0d", t, bus.out_index, bus.out_real, bus.out_imag);
            n_out++;
            last_t = t;
         end
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   task automatic check_bins(input string tag);
      check({tag, "_count"}, n_out, 8);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("%s_idx%0d", tag, k), got_idx[k], k);
         check($sformatf("%s_re%0d", tag, k), got_re[k], exp_re[k]);
         check($sformatf("%s_im%0d", tag, k), got_im[k], exp_im[k]);
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_real   = '0;
      bus.in_imag   = '0;
      bus.out_ready = 1'b0;
`ifdef FFT_SEQ_IFFT_EN
      bus.ifft_mode = 1'b0;
`endif
      do_reset();

      // impulse through the real butterflies, no back-pressure
      model_kind = 0;
      ld_re = '{1, 0, 0, 0, 0, 0, 0, 0};
      ld_im = '{0, 0, 0, 0, 0, 0, 0, 0};
      exp_re = '{1, 1, 1, 1, 1, 1, 1, 1};
      exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_frame(0, 60, 1'b0);
      check_bins("impulse");
      check("frame_last_handshake", last_t, 22);
      check("first_out_valid", first_ov_t, 15);
      #1;
      check("in_ready_after_frame", bus.in_ready, 1);
      check("busy_after_frame", bus.busy, 0);

      // ramp with the marker model: bit-reversed storage and three captures
      model_kind = 1;
      ld_re = '{0, 1, 2, 3, 4, 5, 6, 7};
      ld_im = '{0, -1, -2, -3, -4, -5, -6, -7};
      exp_re = '{7, 11, 9, 13, 8, 12, 10, 14};
      exp_im = '{0, -4, -2, -6, -1, -5, -3, -7};
      run_frame(0, 60, 1'b1);
      check_bins("ramp");

      // out_ready toggling every other cycle
      ld_re = '{100, 103, 106, 109, 112, 115, 118, 121};
      ld_im = '{0, 1, 4, 9, 16, 25, 36, 49};
      exp_re = '{107, 119, 113, 125, 110, 122, 116, 128};
      exp_im = '{0, 16, 4, 36, 1, 25, 9, 49};
      run_frame(1, 80, 1'b0);
      check_bins("backpressure");

      // stage 2 never answers: timeout after 8 WAIT cycles
      model_kind = 0;
      mute = 3'b010;
      ld_re = '{1, 0, 0, 0, 0, 0, 0, 0};
      ld_im = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_frame(0, 30, 1'b0);
      check("err_outputs", n_out, 0);
      check("err_first_cycle", err_t, 20);
      check("err_flag", bus.err, 1);
      check("err_in_ready", bus.in_ready, 0);
      check("err_out_valid", bus.out_valid, 0);
      check("err_stage_start", bus.stage_start, 0);
      check("err_busy", bus.busy, 1);
      mute = 3'b000;
      do_reset();

      // ready in the last allowed WAIT cycle is still captured
      model_lat = 8;
      ld_re = '{3, 3, 3, 3, 3, 3, 3, 3};
      exp_re = '{24, 0, 0, 0, 0, 0, 0, 0};
      exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_frame(0, 120, 1'b0);
      check_bins("ready_wins");
      check("ready_wins_err", bus.err, 0);
      model_lat = 1;

      // reset during the 4th load cycle, then a fresh frame
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_real  = 99;
         bus.in_imag  = 99;
         @(negedge clk);
      end
      do_reset();
      bus.in_valid = 1'b0;
      ld_re = '{2, 2, 2, 2, 2, 2, 2, 2};
      exp_re = '{16, 0, 0, 0, 0, 0, 0, 0};
      run_frame(0, 60, 1'b0);
      check_bins("after_abort");
      check("after_abort_len", last_t, 22);

`ifdef FFT_SEQ_IFFT_EN
      // inverse of the impulse spectrum returns the impulse
      bus.ifft_mode = 1'b1;
      ld_re = '{1, 1, 1, 1, 1, 1, 1, 1};
      exp_re = '{1, 0, 0, 0, 0, 0, 0, 0};
      exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_frame(0, 60, 1'b0);
      check_bins("ifft");
      bus.ifft_mode = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
